// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed, active-low 4-digit seven-segment scan back into digit values.
// Anode and segment buses share one synchronizer and pipeline so every segment sample stays paired with its anode.
module seg_scan_decoder #(
  parameter int SETTLE = 1
) (
  input  logic        sysclock,
  input  logic        reset,
  input  logic [7:0]  annode_selector,
  input  logic [7:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  digit_err,
  output logic        cap_valid,
  output logic [1:0]  cap_index,
  output logic        frame_valid,
  output logic        anode_fault
);

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  logic [3:0] an_s1, an_s2, an_p;
  logic [7:0] seg_s1, seg_s2, seg_p;
  logic [3:0] dwell;
  logic       done;
  logic       fault_p;
  logic [3:0] seen;
  logic [2:0] zero_cnt;
  logic       valid_s2, fault_s2;
  logic       cap_now;
  logic [1:0] cap_k;
  logic [4:0] dec;
  logic [3:0] seen_next;
  logic       unused_low;

  assign unused_low = ^annode_selector[3:0];

  function automatic logic [4:0] decode_glyph(input logic [6:0] s);
    case (s)
      7'h40:   return 5'h00;
      7'h79:   return 5'h01;
      7'h24:   return 5'h02;
      7'h30:   return 5'h03;
      7'h19:   return 5'h04;
      7'h12:   return 5'h05;
      7'h02:   return 5'h06;
      7'h78:   return 5'h07;
      7'h00:   return 5'h08;
      7'h10:   return 5'h09;
      default: return 5'h1F;
    endcase
  endfunction

  always_comb begin
    zero_cnt = '0;
    for (int i = 0; i < 4; i++) zero_cnt = zero_cnt + {2'b00, ~an_s2[i]};
  end

  assign valid_s2 = (zero_cnt == 3'd1);
  assign fault_s2 = (zero_cnt > 3'd1);

  // done blocks a second capture once the dwell counter saturates on a held anode.
  assign cap_now = (dwell == SETTLE_CNT) && !done;

  always_comb begin
    cap_k = 2'd3;
    case (an_p)
      4'b1110: cap_k = 2'd0;
      4'b1101: cap_k = 2'd1;
      4'b1011: cap_k = 2'd2;
      default: cap_k = 2'd3;
    endcase
  end

  assign dec       = decode_glyph(seg_p[6:0]);
  assign seen_next = seen | (4'b0001 << cap_k);

  always_ff @(posedge sysclock or posedge reset) begin
    if (reset) begin
      an_s1  <= 4'hF;
      an_s2  <= 4'hF;
      seg_s1 <= '0;
      seg_s2 <= '0;
    end else begin
      an_s1  <= annode_selector[7:4];
      an_s2  <= an_s1;
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
    end
  end

  always_ff @(posedge sysclock or posedge reset) begin
    if (reset) begin
      an_p        <= 4'hF;
      seg_p       <= '0;
      dwell       <= '0;
      done        <= 1'b0;
      fault_p     <= 1'b0;
      anode_fault <= 1'b0;
    end else begin
      an_p        <= an_s2;
      seg_p       <= seg_s2;
      fault_p     <= fault_s2;
      anode_fault <= fault_s2 && !fault_p;
      if (!valid_s2) begin
        dwell <= '0;
        done  <= 1'b0;
      end else if (an_s2 != an_p) begin
        dwell <= 4'd1;
        done  <= 1'b0;
      end else begin
        if (dwell != 4'd15) dwell <= dwell + 4'd1;
        if (cap_now) done <= 1'b1;
      end
    end
  end

  always_ff @(posedge sysclock or posedge reset) begin
    if (reset) begin
      digits      <= '0;
      dp          <= '0;
      digit_err   <= '0;
      cap_valid   <= 1'b0;
      cap_index   <= '0;
      frame_valid <= 1'b0;
      seen        <= '0;
    end else begin
      cap_valid   <= cap_now;
      frame_valid <= 1'b0;
      if (cap_now) begin
        cap_index                  <= cap_k;
        digits[{cap_k, 2'b00} +: 4] <= dec[3:0];
        digit_err[cap_k]           <= dec[4];
        dp[cap_k]                  <= ~seg_p[7];
        if (seen_next == 4'hF) begin
          frame_valid <= 1'b1;
          seen        <= '0;
        end else begin
          seen <= seen_next;
        end
      end
    end
  end

endmodule
